// File: rtl/aes_core_arbiter.sv
// aes_core_arbiter: shares one AES_top core between two requesters.
// A round-robin grant is taken in IDLE, the core is driven in ISSUE, the tagged
// result is held in RESP until consumed, and GAP lets the core's round logic
// settle before the next grant.
// Optional watchdog on ISSUE is enabled by defining AES_ARB_TIMEOUT_EN.
module aes_core_arbiter #(
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         AES_clk,
    input  logic         AES_rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [127:0] req0_data,
    input  logic [127:0] req0_key,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [127:0] req1_data,
    input  logic [127:0] req1_key,
    output logic         core_en,
    output logic [127:0] core_data,
    output logic [127:0] core_key,
    input  logic         core_out_valid,
    input  logic [127:0] core_out,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [127:0] rsp_data,
    output logic         rsp_err,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP, GAP} state_t;

    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic       last_grant;   // port granted most recently; also owner of the op in flight
    logic       grant;
    logic       grant_port;
    logic       capture;
    logic       timeout;
    logic [3:0] gap_cnt;

`ifdef AES_ARB_TIMEOUT_EN
    localparam logic [9:0] WDOG_LAST = 10'(TIMEOUT_CYCLES - 1);
    logic [9:0] wdog;
    logic       err_q;
`endif

    // Tie goes to the port that did not win last time; otherwise the lone requester wins.
    assign grant_port = (req0_valid && req1_valid) ? ~last_grant : req1_valid;

    // Ready pulses are combinational in the grant cycle; masked during reset so every output reads 0.
    assign req0_ready = AES_rst_n & grant & ~grant_port;
    assign req1_ready = AES_rst_n & grant &  grant_port;
    assign busy       = (state != IDLE);

    // Next-state decode and per-cycle strobes.
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        capture   = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    grant     = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (core_out_valid) begin
                    // A result arriving on the watchdog's last cycle still counts as normal.
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
`ifdef AES_ARB_TIMEOUT_EN
                else if (wdog == WDOG_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = RESP;
                end
`endif
            end
            RESP: begin
                if (rsp_ready) state_nxt = GAP;
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) state <= IDLE;
        else            state <= state_nxt;
    end

    // Grant bookkeeping, core drive, response capture and gap counter.
    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) begin
            last_grant <= 1'b1;
            core_en    <= 1'b0;
            core_data  <= '0;
            core_key   <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
            gap_cnt    <= '0;
        end else begin
            if (grant) begin
                last_grant <= grant_port;
                core_data  <= grant_port ? req1_data : req0_data;
                core_key   <= grant_port ? req1_key  : req0_key;
                core_en    <= 1'b1;
            end
            if (capture || timeout) begin
                core_en   <= 1'b0;
                rsp_valid <= 1'b1;
                rsp_id    <= last_grant;
                rsp_data  <= capture ? core_out : '0;
            end
            if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
                gap_cnt   <= '0;
            end
            if (state == GAP) gap_cnt <= gap_cnt + 4'd1;
        end
    end

`ifdef AES_ARB_TIMEOUT_EN
    // Watchdog counts ISSUE cycles from a clean start and tags timed-out responses.
    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) begin
            wdog  <= '0;
            err_q <= 1'b0;
        end else begin
            if (grant)                                    wdog <= '0;
            else if (state == ISSUE && !capture && !timeout) wdog <= wdog + 10'd1;
            if (capture)      err_q <= 1'b0;
            else if (timeout) err_q <= 1'b1;
        end
    end

    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Directed bench for aes_core_arbiter: contention, single request, backpressure,
// reset during ISSUE and the ISSUE watchdog (or its absence).
module tb_aes_core_arbiter;

    localparam int GAP = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [127:0] req0_data, req0_key, req1_data, req1_key;
    logic         core_en, core_out_valid;
    logic [127:0] core_data, core_key, core_out;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
    logic [127:0] rsp_data;

    int total = 0;
    int bad   = 0;
    int n;

    localparam logic [127:0] D0 = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] D1 = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    localparam logic [127:0] K1 = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    localparam logic [127:0] DS = 128'h0000000b_00000000_00000000_00000000;
    localparam logic [127:0] KS = 128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc;

    aes_core_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(64)) dut (
        .AES_clk(clk), .AES_rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_key(req0_key),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_key(req1_key),
        .core_en(core_en), .core_data(core_data), .core_key(core_key),
        .core_out_valid(core_out_valid), .core_out(core_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next falling edge.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_grant(input logic port, output int cycles);
        cycles = 0;
        while (!(req0_ready || req1_ready) && cycles < 100) begin
            step();
            cycles++;
        end
        chk("grant_seen", cycles < 100, 1);
        chk("grant_port", req1_ready, port);
        chk("grant_onehot", req0_ready & req1_ready, 0);
    endtask

    // Entered in the grant cycle; returns in the first IDLE cycle after GAP.
    task automatic run_op(input logic port, input logic [127:0] d, input logic [127:0] k,
                          input logic [127:0] c, input int lat, input int hold,
                          input logic drop, input logic raise1);
        step();
        if (drop) begin
            if (port) req1_valid = 1'b0;
            else      req0_valid = 1'b0;
        end
        if (raise1) begin
            req1_valid = 1'b1;
            req1_data  = D1;
            req1_key   = K1;
        end
        #1;
        chk("issue_en", core_en, 1);
        chk("issue_data", core_data, d);
        chk("issue_key", core_key, k);
        chk("issue_busy", busy, 1);
        chk("issue_norsp", rsp_valid, 0);
        chk("issue_noready", req0_ready | req1_ready, 0);
        for (int i = 1; i < lat; i++) begin
            step();
            chk("issue_en_hold", core_en, 1);
            chk("issue_data_hold", core_data, d);
            chk("issue_key_hold", core_key, k);
        end
        core_out_valid = 1'b1;
        core_out       = c;
        step();
        core_out_valid = 1'b0;
        core_out       = '0;
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_id", rsp_id, port);
        chk("rsp_data", rsp_data, c);
        chk("rsp_err", rsp_err, 0);
        chk("rsp_core_en", core_en, 0);
        for (int i = 0; i < hold; i++) begin
            core_out_valid = 1'b1;     // stray result outside ISSUE must be ignored
            core_out       = ~c;
            step();
            core_out_valid = 1'b0;
            chk("hold_valid", rsp_valid, 1);
            chk("hold_data", rsp_data, c);
            chk("hold_id", rsp_id, port);
            chk("hold_noready", req0_ready | req1_ready, 0);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        for (int g = 0; g < GAP; g++) begin
            chk("gap_rsp_low", rsp_valid, 0);
            chk("gap_en_low", core_en, 0);
            chk("gap_busy", busy, 1);
            chk("gap_noready", req0_ready | req1_ready, 0);
            step();
        end
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b0;
        req0_data = D0; req0_key = K0; req1_data = D1; req1_key = K1;
        core_out_valid = 1'b0; core_out = '0; rsp_ready = 1'b0;
        repeat (2) step();
        chk("rst_ready0", req0_ready, 0);
        chk("rst_core_en", core_en, 0);
        chk("rst_core_data", core_data, 0);
        chk("rst_core_key", core_key, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_busy", busy, 0);

        // Contention: both ports held, grants 0,1,0 back to back through GAP.
        rst_n = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        wait_grant(0, n); chk("cont1_delay", n, 0);
        run_op(0, D0, K0, 128'hc0c0_0001, 4, 0, 0, 0);
        wait_grant(1, n); chk("cont2_delay", n, 0);
        run_op(1, D1, K1, 128'hc1c1_0002, 3, 0, 0, 0);
        wait_grant(0, n); chk("cont3_delay", n, 0);
        req1_valid = 1'b0;
        run_op(0, D0, K0, 128'hc0c0_0003, 2, 0, 1, 0);
        step();
        chk("cont_idle_noready", req0_ready | req1_ready, 0);

        // Single request with the reference plaintext/key.
        req0_valid = 1'b1; req0_data = DS; req0_key = KS;
        #1;
        wait_grant(0, n);
        run_op(0, DS, KS, 128'h5ca1ab1e_0ddba11_feedface_01020304, 5, 0, 1, 0);

        // Backpressure: response held 10 cycles, req1 pending but not granted until after GAP.
        req0_valid = 1'b1; req0_data = D0; req0_key = K0;
        #1;
        wait_grant(0, n);
        run_op(0, D0, K0, 128'hbbbb_cccc_dddd, 3, 10, 1, 1);
        wait_grant(1, n); chk("bp_grant_delay", n, 0);
        run_op(1, D1, K1, 128'h1111_2222_3333, 2, 0, 1, 0);

        // Reset five cycles into ISSUE; last_grant returns to 1 so port 0 wins the next tie.
        req0_valid = 1'b1;
        #1;
        wait_grant(0, n);
        step();
        req0_valid = 1'b0;
        repeat (4) step();
        chk("pre_rst_en", core_en, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_core_en", core_en, 0);
        chk("arst_busy", busy, 0);
        chk("arst_rsp_valid", rsp_valid, 0);
        chk("arst_core_data", core_data, 0);
        step();
        step();
        rst_n = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("post_rst_norsp", rsp_valid, 0);
        wait_grant(0, n); chk("post_rst_delay", n, 0);
        run_op(0, D0, K0, 128'h4444_5555, 2, 0, 1, 0);
        wait_grant(1, n);
        run_op(1, D1, K1, 128'h6666_7777, 3, 0, 1, 0);

`ifdef AES_ARB_TIMEOUT_EN
        // Watchdog: 64 ISSUE cycles with no result, then an error response.
        req0_valid = 1'b1;
        #1;
        wait_grant(0, n);
        step();
        req0_valid = 1'b0;
        repeat (63) step();
        chk("to_last_issue_en", core_en, 1);
        chk("to_last_issue_norsp", rsp_valid, 0);
        step();
        chk("to_rsp_valid", rsp_valid, 1);
        chk("to_rsp_err", rsp_err, 1);
        chk("to_rsp_data", rsp_data, 0);
        chk("to_rsp_id", rsp_id, 0);
        chk("to_core_en", core_en, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        repeat (GAP) step();
        chk("to_idle", busy, 0);
`else
        // No watchdog: ISSUE waits indefinitely.
        req0_valid = 1'b1;
        #1;
        wait_grant(0, n);
        step();
        req0_valid = 1'b0;
        repeat (199) step();
        chk("nto_busy", busy, 1);
        chk("nto_norsp", rsp_valid, 0);
        chk("nto_en", core_en, 1);
        chk("nto_err", rsp_err, 0);
        rst_n = 1'b0;
        #1;
        chk("nto_rst_busy", busy, 0);
        step();
        rst_n = 1'b1;
        step();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_core_arbiter.md
Name: aes_core_arbiter

Overview:
- Shares one AES_top encryption core between two requesters (port 0, port 1).
- Accepts a plaintext/key pair from a requester and drives the core's AES_en, AES_data_in and AES_key_in.
- Waits for AES_data_out_valid, then returns the ciphertext tagged with the requester ID.
- Sits between the system-side request interfaces and the single AES_top instance.

Parameters:
- GAP_CYCLES, 2: cycles core_en is held low between consecutive operations so the core's round logic returns to idle; legal range 1..15.
- TIMEOUT_CYCLES, 64: maximum cycles in ISSUE before the watchdog aborts; used only with the optional feature; legal range 16..1023.

Ports:
- AES_clk  in  1  clock; all logic on the rising edge.
- AES_rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has a pending operation.
- req0_ready  out  1  one-cycle accept pulse to requester 0.
- req0_data  in  128  requester 0 plaintext.
- req0_key  in  128  requester 0 key.
- req1_valid, req1_ready, req1_data, req1_key: same as port 0, for requester 1.
- core_en  out  1  to AES_top AES_en.
- core_data  out  128  to AES_top AES_data_in.
- core_key  out  128  to AES_top AES_key_in.
- core_out_valid  in  1  from AES_top AES_data_out_valid.
- core_out  in  128  from AES_top AES_data_out.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  1  requester that owns the response.
- rsp_data  out  128  ciphertext.
- rsp_err  out  1  response aborted by timeout.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (asynchronous, while AES_rst_n=0): state=IDLE, last_grant=1 (port 0 wins first), and every output is 0, including core_data, core_key, rsp_data and the counters.
- FSM states: IDLE, ISSUE, RESP, GAP.
- IDLE:
  - If any reqN_valid=1, grant that port with round-robin priority: on a tie, grant the port not equal to last_grant.
  - In the grant cycle, assert reqN_ready=1 for exactly one cycle.
  - Register reqN_data/reqN_key into core_data/core_key, update last_grant, and go to ISSUE.
  - Requests are never accepted outside IDLE.
- ISSUE:
  - core_en=1, asserted from the cycle after the grant.
  - core_data and core_key are held stable for the whole state.
  - On the first cycle with core_out_valid=1: capture core_out into rsp_data, set rsp_id to the granted port, set rsp_err=0, and go to RESP.
  - core_en falls in the same edge.
- RESP:
  - rsp_valid=1; rsp_data, rsp_id and rsp_err are held stable until a cycle with rsp_ready=1.
  - After that cycle, go to GAP; rsp_valid drops on that edge.
  - rsp_ready is ignored while rsp_valid=0.
- GAP:
  - core_en=0; a counter counts GAP_CYCLES, then goes to IDLE.
  - Minimum issue-to-issue spacing is core latency + 1 (RESP) + GAP_CYCLES + 1 (IDLE grant).
- core_out_valid outside ISSUE is ignored; no capture, no state change.
- Latency, grant to rsp_valid: core latency + 1 cycle.
- Reset asserted mid-operation:
  - Immediate return to IDLE with all outputs 0 and core_en low.
  - The in-flight operation is discarded with no response.
  - last_grant is reset.
- Back-to-back requests from one port while the other port is idle are allowed; each waits through GAP.

Optional Feature:
- Macro: AES_ARB_TIMEOUT_EN.
- Defined:
  - A 10-bit watchdog clears on entry to ISSUE and counts every ISSUE cycle.
  - If it reaches TIMEOUT_CYCLES without core_out_valid, go to RESP with rsp_data=0, rsp_err=1, and core_en=0 from the next cycle.
  - A core_out_valid in the same cycle the counter hits the limit wins: it is a normal response with rsp_err=0.
- Undefined: no watchdog; ISSUE waits indefinitely; rsp_err is tied to 0.

Test Plan:
- Single request: req0 with data 0000000b_00000000_00000000_00000000 and key aa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc.
  - Expect req0_ready to pulse one cycle.
  - core_en is high until core_out_valid.
  - core_data and core_key equal the inputs throughout.
  - rsp_valid with rsp_id=0 and rsp_data equal to the core ciphertext.
- Contention: req0_valid and req1_valid both held high for 3 operations after reset.
  - Grants go 0, 1, 0; rsp_id follows the same order.
  - Each grant is separated by at least GAP_CYCLES=2 cycles with core_en low.
- Backpressure: rsp_ready held low for 10 cycles after rsp_valid.
  - rsp_data and rsp_id stay stable for all 10 cycles.
  - No new grant occurs even with req1_valid=1.
  - The grant follows only after the rsp_ready pulse plus GAP.
- Reset in ISSUE: assert AES_rst_n=0 five cycles after the grant, for 2 cycles.
  - core_en, busy and rsp_valid are 0 immediately (asynchronous).
  - No response is ever produced for the aborted request.
  - A new req1 after release is granted normally.
- Timeout (AES_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=64): core_out_valid is held 0.
  - 64 cycles after entering ISSUE, expect rsp_valid=1, rsp_err=1, rsp_data=0 and core_en=0.
  - The same test with the macro undefined shows busy=1 and no rsp_valid after 200 cycles.
